// File: rtl/add_slice_seq_if.sv
// ----------------------------------------------------------------------------
// add_slice_seq_if
//   Operand/result bundle for the slice-sequenced wide adder.
//   master : operand source + result consumer (drives in_valid, x1, x2, cin,
//            out_ready; observes in_ready, out_valid, s, cout, skip_cnt, busy)
//   slave  : the adder itself (the mirror image of master)
// Parameters:
//   WIDTH  operand / sum width in bits
//   CNTW   width of the skip counter
// ----------------------------------------------------------------------------
interface add_slice_seq_if #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic [CNTW-1:0]  skip_cnt;
  logic             busy;

  modport master (
    output in_valid, x1, x2, cin, out_ready,
    input  in_ready, out_valid, s, cout, skip_cnt, busy
  );

  modport slave (
    input  in_valid, x1, x2, cin, out_ready,
    output in_ready, out_valid, s, cout, skip_cnt, busy
  );
endinterface

// File: rtl/add_slice_seq.sv
// ----------------------------------------------------------------------------
// add_slice_seq
//   Multi-cycle wide adder. One SLICE-bit carry-skip slice is reused over
//   NSLICE = WIDTH/SLICE cycles; the carry is carried between slices in a
//   register, and a slice whose group-propagate is all ones passes its
//   carry-in straight through (counted in skip_cnt).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   add_slice_seq_if.slave: in_valid/in_ready + x1, x2, cin operand
//         handshake; out_valid/out_ready + s, cout, skip_cnt result
//         handshake; busy is high while an operation is in flight or held.
// Parameters:
//   WIDTH  operand width (integer multiple of SLICE)
//   SLICE  slice width processed per cycle
//   CNTW   slice index / skip counter width (2**CNTW > NSLICE)
// ----------------------------------------------------------------------------
module add_slice_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16,
  parameter int CNTW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  add_slice_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNTW-1:0]  idx_q, idx_d;
  logic [CNTW-1:0]  skip_q, skip_d;

  // Shared slice datapath, operating on slice idx_q.
  logic [SLICE-1:0] a_k, b_k;
  logic [SLICE:0]   sum_ext;
  logic             gp;
  logic             carry_next;
  logic             last_slice;

  always_comb begin
    a_k        = a_q[idx_q*SLICE +: SLICE];
    b_k        = b_q[idx_q*SLICE +: SLICE];
    sum_ext    = {1'b0, a_k} + {1'b0, b_k} + {{SLICE{1'b0}}, carry_q};
    gp         = &(a_k ^ b_k);
    // When every bit propagates, the ripple carry-out equals the carry-in;
    // the skip path is taken architecturally so it can be counted.
    carry_next = gp ? carry_q : sum_ext[SLICE];
    last_slice = (idx_q == CNTW'(NSLICE - 1));
  end

  always_comb begin
    // NOTE: every _d signal takes its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    skip_d  = skip_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.x1;
          b_d     = bus.x2;
          carry_d = bus.cin;
          idx_d   = '0;
          s_d     = '0;
          skip_d  = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        s_d[idx_q*SLICE +: SLICE] = sum_ext[SLICE-1:0];
        skip_d  = skip_q + CNTW'(gp);
        carry_d = carry_next;
        if (last_slice) begin
          cout_d  = carry_next;
          state_d = DONE;
        end else begin
          idx_d = idx_q + CNTW'(1);
        end
      end

      DONE: begin
        // A new operand can only be taken once back in IDLE, so a result
        // handshake and a pending in_valid never overlap.
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      skip_q  <= skip_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.skip_cnt  = skip_q;

endmodule

// File: tb/tb_add_slice_seq.sv
// ----------------------------------------------------------------------------
// tb_add_slice_seq
//   Self-checking bench for add_slice_seq (WIDTH=64, SLICE=16, CNTW=3).
//   Expected sums come from plain 65-bit arithmetic and the skip count from
//   counting 16-bit groups of x1^x2 that are all ones.
// ----------------------------------------------------------------------------
module tb_add_slice_seq;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int CNTW   = 3;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  add_slice_seq_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  add_slice_seq #(.WIDTH(WIDTH), .SLICE(SLICE), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges despite the bounded loops.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (tests=%0d failed=%0d)",
             tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  // Drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Reference: sum modulo 2^WIDTH with carry out, plus the number of
  // SLICE-bit groups in which every bit position propagates.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic c, output logic [WIDTH-1:0] es,
                                output logic ec, output logic [CNTW-1:0] ek);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] p;
    int               n;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    es   = full[WIDTH-1:0];
    ec   = full[WIDTH];
    p    = a ^ b;
    n    = 0;
    for (int k = 0; k < NSLICE; k++)
      if (p[k*SLICE +: SLICE] == {SLICE{1'b1}}) n++;
    ek = CNTW'(n);
  endfunction

  // Runs one operation from IDLE: presents operands, scrambles inputs after
  // acceptance, waits (bounded) for out_valid, holds out_ready low for
  // 'hold' cycles, then consumes the result. Returns observations only.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input int hold,
                       output logic [WIDTH-1:0] rs, output logic rc,
                       output logic [CNTW-1:0] rk, output int lat,
                       output bit stable_ok, output bit ready_ok);
    bus.x1        = a;
    bus.x2        = b;
    bus.cin       = c;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.x1       = rand64();
    bus.x2       = rand64();
    bus.cin      = 1'($urandom);
    lat      = 0;
    ready_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ready_ok = 1'b0;
      tick();
      lat++;
    end
    rs = bus.s;
    rc = bus.cout;
    rk = bus.skip_cnt;
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      tick();
      if (bus.s !== rs || bus.cout !== rc || bus.skip_cnt !== rk ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
        stable_ok = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      ready_ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH+4:0] got;
    logic [WIDTH+4:0] exp;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x1        = '0;
    bus.x2        = '0;
    bus.cin       = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // {in_ready, out_valid, busy, cout, s} in IDLE after reset
    exp = {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}};
    for (int i = 0; i < 10; i++) begin
      got = {bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.s};
      tests_run++;
      if (got !== exp || bus.skip_cnt !== '0) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d got {rdy,ov,busy,cout,s}=%h skip=%0d want %h skip=0",
                 i, got, bus.skip_cnt, exp);
      end
      tick();
    end
  endtask

  task automatic test_directed(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic c);
    logic [WIDTH-1:0] rs, es;
    logic             rc, ec;
    logic [CNTW-1:0]  rk, ek;
    int               lat;
    bit               st, rd;
    model(a, b, c, es, ec, ek);
    do_op(a, b, c, 2, rs, rc, rk, lat, st, rd);
    tests_run++;
    if (lat !== NSLICE) begin
      tests_failed++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, NSLICE);
    end
    tests_run++;
    if ({rc, rs} !== {ec, es}) begin
      tests_failed++;
      $display("FAIL %s_sum got cout=%0b s=%h want cout=%0b s=%h", name, rc, rs, ec, es);
    end
    tests_run++;
    if (rk !== ek) begin
      tests_failed++;
      $display("FAIL %s_skip got %0d want %0d", name, rk, ek);
    end
    tests_run++;
    if (!(st && rd)) begin
      tests_failed++;
      $display("FAIL %s_handshake got stable=%0b ready=%0b want 1 1", name, st, rd);
    end
  endtask

  task automatic test_random(input int n_ops);
    logic [WIDTH-1:0] a, b, rs, es;
    logic             c, rc, ec;
    logic [CNTW-1:0]  rk, ek;
    int               lat;
    bit               st, rd;
    for (int i = 0; i < n_ops; i++) begin
      a = rand64();
      b = rand64();
      c = 1'($urandom);
      // Force some all-propagate groups so the skip count gets exercised.
      for (int k = 0; k < NSLICE; k++)
        if ($urandom_range(3) == 0) b[k*SLICE +: SLICE] = ~a[k*SLICE +: SLICE];
      model(a, b, c, es, ec, ek);
      do_op(a, b, c, $urandom_range(3), rs, rc, rk, lat, st, rd);
      tests_run++;
      if ({rc, rs} !== {ec, es} || rk !== ek || lat !== NSLICE) begin
        tests_failed++;
        $display("FAIL rand_op%0d a=%h b=%h c=%0b got cout=%0b s=%h skip=%0d lat=%0d want cout=%0b s=%h skip=%0d lat=%0d",
                 i, a, b, c, rc, rs, rk, lat, ec, es, ek, NSLICE);
      end
      tests_run++;
      if (!(st && rd)) begin
        tests_failed++;
        $display("FAIL rand_hs%0d got stable=%0b ready=%0b want 1 1", i, st, rd);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit               seen_ov;
    logic [WIDTH-1:0] rs;
    logic             rc;
    logic [CNTW-1:0]  rk;
    int               lat;
    bit               st, rd;
    bus.x1       = 64'h1234;
    bus.x2       = 64'h1;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.s !== '0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_state got s=%h busy=%0b ov=%0b rdy=%0b want s=0 busy=0 ov=0 rdy=1",
               bus.s, bus.busy, bus.out_valid, bus.in_ready);
    end
    tick();
    rst = 1'b0;
    seen_ov = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen_ov = 1'b1;
      tick();
    end
    tests_run++;
    if (seen_ov) begin
      tests_failed++;
      $display("FAIL mid_reset_no_result got out_valid/busy activity=1 want 0");
    end
    do_op(64'd5, 64'd7, 1'b0, 0, rs, rc, rk, lat, st, rd);
    tests_run++;
    if ({rc, rs} !== {1'b0, 64'd12} || lat !== NSLICE) begin
      tests_failed++;
      $display("FAIL mid_reset_next_op got cout=%0b s=%h lat=%0d want cout=0 s=c lat=%0d",
               rc, rs, lat, NSLICE);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a1, b1, a2, b2, es1, es2;
    logic             ec1, ec2;
    logic [CNTW-1:0]  ek1, ek2;
    int               lat;
    bit               ok;
    a1 = rand64(); b1 = rand64();
    a2 = rand64(); b2 = rand64();
    model(a1, b1, 1'b1, es1, ec1, ek1);
    model(a2, b2, 1'b0, es2, ec2, ek2);
    bus.x1 = a1; bus.x2 = b1; bus.cin = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    // Second operand set is presented throughout and must wait.
    bus.x1 = a2; bus.x2 = b2; bus.cin = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    ok = (lat == NSLICE);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.s !== es1) ok = 1'b0;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL b2b_hold got s=%h rdy=%0b ov=%0b lat=%0d want s=%h rdy=0 ov=1 lat=%0d",
               bus.s, bus.in_ready, bus.out_valid, lat, es1, NSLICE);
    end
    bus.out_ready = 1'b1;
    tick();  // result handshake edge
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.s !== es1 || bus.cout !== ec1 ||
        bus.skip_cnt !== ek1) begin
      tests_failed++;
      $display("FAIL b2b_after_consume got busy=%0b rdy=%0b s=%h cout=%0b skip=%0d want 0 1 %h %0b %0d",
               bus.busy, bus.in_ready, bus.s, bus.cout, bus.skip_cnt, es1, ec1, ek1);
    end
    tick();  // acceptance edge for the second operation
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept_next got busy=%0b rdy=%0b want 1 0", bus.busy, bus.in_ready);
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    tests_run++;
    if ({bus.cout, bus.s} !== {ec2, es2} || bus.skip_cnt !== ek2 || lat !== NSLICE) begin
      tests_failed++;
      $display("FAIL b2b_second got cout=%0b s=%h skip=%0d lat=%0d want cout=%0b s=%h skip=%0d lat=%0d",
               bus.cout, bus.s, bus.skip_cnt, lat, ec2, es2, ek2, NSLICE);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed("full_skip", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    test_directed("generate", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    test_directed("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    test_mid_reset();
    test_back_to_back();
    test_random(2000);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
